// File: rtl/fifo_wptr_full_pkg.sv
// Shared definitions for the asynchronous FIFO write/read pointer controllers.
//  ADDRSIZE_DEF     default memory address width (DEPTH = 1 << ADDRSIZE)
//  AFULL_MARGIN_DEF default almost-full margin in free entries
//  bin2gray()       binary to reflected-Gray conversion, truncated by the caller
package fifo_wptr_full_pkg;

    localparam int unsigned ADDRSIZE_DEF     = 4;
    localparam int unsigned AFULL_MARGIN_DEF = 2;
    localparam int unsigned CODE_MAX_W       = 32;

    function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_wptr_full_gray2bin.sv
// Gray to binary converter, shared by the write- and read-side pointer controllers.
//  gray  in  W  Gray-coded value
//  bin   out W  binary value, combinational (bin[i] = ^gray[W-1:i])
module fifo_wptr_full_gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Prefix XOR from the MSB down; shifting right zero-fills so only gray[W-1:i] contributes.
    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(W); i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side control of the asynchronous FIFO: qualifies writes, drives the memory
// write port, keeps the binary/Gray write pointer and derives full/almost-full/level/
// overflow from the read pointer already synchronised into wclk.
//  wclk, wrst_n  clock and synchronous active-low reset
//  winc          producer write request
//  wq2_rptr      synchronised Gray read pointer
//  w_en          memory write enable (combinational)
//  waddr         memory write address (low bits of the binary pointer)
//  wptr          registered Gray write pointer for the read-side synchroniser
//  wfull         registered full flag
//  walmost_full  registered almost-full flag
//  wlevel        registered fill level 0..DEPTH, lags reads by the synchroniser
//  wovf          sticky overflow, set by a write request while full
module fifo_wptr_full
    import fifo_wptr_full_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = ADDRSIZE_DEF,
    parameter int unsigned AFULL_MARGIN = AFULL_MARGIN_DEF
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                w_en,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int unsigned PW    = ADDRSIZE + 1;
    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam logic [PW-1:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rptr_full_code;

    fifo_wptr_full_gray2bin #(
        .W (PW)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // A request is dropped while full or while reset is held.
    assign w_en  = winc & ~wfull & wrst_n;
    assign waddr = wbin[ADDRSIZE-1:0];

    // Next pointer, its Gray image and the level it implies against the read pointer.
    always_comb begin
        wbinnext       = wbin + PW'(w_en);
        wgraynext      = PW'(bin2gray(CODE_MAX_W'(wbinnext)));
        level_next     = wbinnext - rbin;
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        rptr_full_code = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    end

    // Pointer and flag registers.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= (wgraynext == rptr_full_code);
            walmost_full <= (level_next >= AFULL_THRESH);
            wlevel       <= level_next;
            wovf         <= wovf | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ADDRSIZE=4, AFULL_MARGIN=2). The reference model
// counts accepted writes and consumed reads as plain integers; expected outputs are
// queued by the driver and popped by two independent monitors.
module tb_fifo_wptr_full;

    localparam int DEPTH = 16;
    localparam int MARGIN = 2;

    typedef struct packed {
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = 5'd0;
    logic       w_en;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    fifo_wptr_full #(
        .ADDRSIZE     (4),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .w_en         (w_en),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    always #5 wclk = ~wclk;

    int   errors = 0;
    int   checks = 0;
    logic q_wen[$];
    exp_t q_state[$];

    // Reference model: total writes accepted and reads seen, since last reset.
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic m_full = 1'b0;
    logic m_ovf = 1'b0;
    int   max_level_wrap = 0;
    logic full_seen_wrap = 1'b0;

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    // One write-clock cycle: drive inputs after the falling edge, queue expectations.
    task automatic step(input logic rst_n_v, input logic inc, input int rd);
        logic exp_wen;
        int   lvl;
        exp_t e;
        @(negedge wclk);
        wrst_n = rst_n_v;
        winc   = inc;
        rd_cnt = rst_n_v ? rd : 0;
        wq2_rptr = gray5(rd_cnt);
        #1;
        exp_wen = rst_n_v && inc && !m_full;
        q_wen.push_back(exp_wen);
        if (!rst_n_v) begin
            wr_cnt = 0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            lvl    = 0;
        end else begin
            if (inc && m_full) m_ovf = 1'b1;
            if (exp_wen) wr_cnt++;
            lvl    = wr_cnt - rd_cnt;
            m_full = (lvl == DEPTH);
        end
        e.wptr  = gray5(wr_cnt);
        e.waddr = 4'(wr_cnt % DEPTH);
        e.full  = m_full;
        e.afull = (lvl >= DEPTH - MARGIN);
        e.level = 5'(lvl);
        e.ovf   = m_ovf;
        q_state.push_back(e);
    endtask

    // Combinational write enable, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge wclk);
            #2;
            if (q_wen.size() > 0) begin
                logic ew;
                ew = q_wen.pop_front();
                checks++;
                if (w_en !== ew) begin
                    errors++;
                    $display("FAIL w_en t=%0t got=%b exp=%b", $time, w_en, ew);
                end
            end
        end
    end

    // Registered outputs, sampled just after the rising edge.
    initial begin
        forever begin
            @(posedge wclk);
            #1;
            if (q_state.size() > 0) begin
                exp_t e;
                e = q_state.pop_front();
                checks++;
                if (wptr !== e.wptr || waddr !== e.waddr || wfull !== e.full ||
                    walmost_full !== e.afull || wlevel !== e.level || wovf !== e.ovf) begin
                    errors++;
                    $display("FAIL state t=%0t got wptr=%b waddr=%0d full=%b afull=%b level=%0d ovf=%b exp wptr=%b waddr=%0d full=%b afull=%b level=%0d ovf=%b",
                             $time, wptr, waddr, wfull, walmost_full, wlevel, wovf,
                             e.wptr, e.waddr, e.full, e.afull, e.level, e.ovf);
                end
            end
        end
    end

    initial begin
        int hist[$];
        int rd;

        // Reset held with a write request present.
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);

        // Fill from empty.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 0);

        // Overflow attempts, then request removed.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0);

        // Read pointer advances to 4: full releases, level 12.
        step(1'b1, 1'b0, 4);
        step(1'b1, 1'b1, 4);

        // Drain, then 40 writes with the read pointer trailing three cycles behind.
        step(1'b1, 1'b0, wr_cnt);
        for (int i = 0; i < 40; i++) begin
            rd = (hist.size() >= 3) ? hist[hist.size() - 3] : rd_cnt;
            step(1'b1, 1'b1, rd);
            hist.push_back(wr_cnt);
            if (wr_cnt - rd_cnt > max_level_wrap) max_level_wrap = wr_cnt - rd_cnt;
            if (m_full) full_seen_wrap = 1'b1;
        end
        checks++;
        if (max_level_wrap > 3 || full_seen_wrap) begin
            errors++;
            $display("FAIL wrap_bound got max_level=%0d full=%b exp max_level<=3 full=0",
                     max_level_wrap, full_seen_wrap);
        end

        // Reset arriving on the seventh write of a burst.
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);

        // Random traffic with monotonic read progress and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic inc;
            r   = ($urandom_range(0, 79) != 0);
            inc = ($urandom_range(0, 3) != 0);
            rd  = rd_cnt;
            if ($urandom_range(0, 2) == 0) rd = rd_cnt + $urandom_range(0, wr_cnt - rd_cnt);
            step(r, inc, rd);
        end
        step(1'b1, 1'b0, rd_cnt);

        // Let the monitors drain, bounded.
        for (int i = 0; i < 10 && (q_wen.size() > 0 || q_state.size() > 0); i++) @(posedge wclk);
        #3;
        if (q_wen.size() > 0 || q_state.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got pending=%0d exp pending=0", q_wen.size() + q_state.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
